// File: rtl/text_lcd_rx.sv
// Receiver model of an HD44780-style 8-bit LCD bus: decodes writes into mode flags, address counter and 2x40 DDRAM.
// Writes take effect on the accepting edge; rd_char is registered (1 cycle); writes during a clear fill are dropped and flagged.
module text_lcd_rx #(
  parameter bit ENB_EDGE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enb,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic       rd_line,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       func_dl,
  output logic       func_n,
  output logic       func_f,
  output logic [6:0] cur_addr,
  output logic       err_pulse,
  output logic       err_flag
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [6:0] fill_q, fill_d;
  logic       enb_prev_q;
  logic [7:0] ram_q [0:79];

  logic       disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic       inc_q, inc_d, shift_q, shift_d;
  logic       dl_q, dl_d, n_q, n_d, f_q, f_d;
  logic       cg_q, cg_d;
  logic [6:0] addr_q, addr_d;
  logic       err_pulse_q, err_pulse_d, err_flag_q, err_flag_d;
  logic [7:0] rd_char_q, rd_char_d;

  logic       strobe, wr_acc, clear_cmd, ddram_ok;
  logic       ram_we;
  logic [6:0] ram_waddr, rd_index;
  logic [7:0] ram_wdata;

  // Address counter walks 0x00..0x27 then 0x40..0x67 as one ring.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  function automatic logic [6:0] ram_index(input logic [6:0] a);
    return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
  endfunction

  always_comb begin
    strobe    = ENB_EDGE ? (enb_prev_q & ~lcd_enb) : lcd_enb;
    wr_acc    = strobe & ~lcd_rw;
    clear_cmd = wr_acc & (state_q == S_IDLE) & ~lcd_rs & (lcd_data == 8'h01);
    ddram_ok  = (lcd_data[6:0] <= 7'h27) ||
                ((lcd_data[6:0] >= 7'h40) && (lcd_data[6:0] <= 7'h67));
    rd_index  = rd_line ? (7'd40 + {3'b000, rd_col}) : {3'b000, rd_col};
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      fill_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      S_CLEAR: begin
        fill_d = fill_q + 7'd1;
        if (fill_q == 7'd79) begin
          state_d = S_IDLE;
          fill_d  = 7'd0;
        end
      end
      S_IDLE: begin
        if (clear_cmd) begin
          state_d = S_CLEAR;
          fill_d  = 7'd0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_CLEAR);
  end

  always_comb begin
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    blink_d     = blink_q;
    inc_d       = inc_q;
    shift_d     = shift_q;
    dl_d        = dl_q;
    n_d         = n_q;
    f_d         = f_q;
    cg_d        = cg_q;
    addr_d      = addr_q;
    err_pulse_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = fill_q;
    ram_wdata   = 8'h20;
    if (state_q == S_CLEAR) begin
      ram_we = 1'b1;
      if (wr_acc) err_pulse_d = 1'b1;
    end else if (wr_acc) begin
      if (lcd_rs) begin
        if (!cg_q) begin
          ram_we    = 1'b1;
          ram_waddr = ram_index(addr_q);
          ram_wdata = lcd_data;
          addr_d    = step_addr(addr_q, inc_q);
        end
      end else begin
        casez (lcd_data)
          8'b1???????: begin
            if (ddram_ok) begin
              addr_d = lcd_data[6:0];
              cg_d   = 1'b0;
            end else begin
              err_pulse_d = 1'b1;
            end
          end
          8'b01??????: cg_d = 1'b1;
          8'b001?????: begin
            dl_d = lcd_data[4];
            n_d  = lcd_data[3];
            f_d  = lcd_data[2];
          end
          8'b0001????: begin
            if (!lcd_data[3]) addr_d = step_addr(addr_q, lcd_data[2]);
          end
          8'b00001???: begin
            disp_d   = lcd_data[2];
            cursor_d = lcd_data[1];
            blink_d  = lcd_data[0];
          end
          8'b000001??: begin
            inc_d   = lcd_data[1];
            shift_d = lcd_data[0];
          end
          8'b0000001?: begin
            addr_d = 7'h00;
            cg_d   = 1'b0;
          end
          8'b00000001: begin
            addr_d = 7'h00;
            inc_d  = 1'b1;
            cg_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
    err_flag_d = err_flag_q | err_pulse_d;
    rd_char_d  = ram_q[rd_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enb_prev_q  <= 1'b0;
      disp_q      <= 1'b0;
      cursor_q    <= 1'b0;
      blink_q     <= 1'b0;
      inc_q       <= 1'b1;
      shift_q     <= 1'b0;
      dl_q        <= 1'b1;
      n_q         <= 1'b0;
      f_q         <= 1'b0;
      cg_q        <= 1'b0;
      addr_q      <= 7'h00;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      rd_char_q   <= 8'h00;
    end else begin
      enb_prev_q  <= lcd_enb;
      disp_q      <= disp_d;
      cursor_q    <= cursor_d;
      blink_q     <= blink_d;
      inc_q       <= inc_d;
      shift_q     <= shift_d;
      dl_q        <= dl_d;
      n_q         <= n_d;
      f_q         <= f_d;
      cg_q        <= cg_d;
      addr_q      <= addr_d;
      err_pulse_q <= err_pulse_d;
      err_flag_q  <= err_flag_d;
      rd_char_q   <= rd_char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  assign rd_char    = rd_char_q;
  assign disp_on    = disp_q;
  assign cursor_on  = cursor_q;
  assign blink_on   = blink_q;
  assign inc_mode   = inc_q;
  assign shift_mode = shift_q;
  assign func_dl    = dl_q;
  assign func_n     = n_q;
  assign func_f     = f_q;
  assign cur_addr   = addr_q;
  assign err_pulse  = err_pulse_q;
  assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_text_lcd_rx.sv
// Bench for text_lcd_rx: level-strobe instance for the main decode, edge-strobe instance for ENB_EDGE and mid-clear reset.
module tb_text_lcd_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, lcd_enb, lcd_rs, lcd_rw, rd_line;
  logic [7:0] lcd_data;
  logic [3:0] rd_col;
  logic [7:0] rd_char;
  logic       busy, disp_on, cursor_on, blink_on, inc_mode, shift_mode;
  logic       func_dl, func_n, func_f, err_pulse, err_flag;
  logic [6:0] cur_addr;

  logic       rst1, enb1, rs1, rw1, rd_line1;
  logic [7:0] data1;
  logic [3:0] rd_col1;
  logic [7:0] rd_char1;
  logic       busy1, disp1, cursor1, blink1, inc1, shift1;
  logic       dl1, n1, f1, errp1, errf1;
  logic [6:0] cur1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  text_lcd_rx #(.ENB_EDGE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .lcd_enb(lcd_enb), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char),
    .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .shift_mode(shift_mode), .func_dl(func_dl), .func_n(func_n),
    .func_f(func_f), .cur_addr(cur_addr), .err_pulse(err_pulse), .err_flag(err_flag)
  );

  text_lcd_rx #(.ENB_EDGE(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .lcd_enb(enb1), .lcd_rs(rs1), .lcd_rw(rw1),
    .lcd_data(data1), .rd_line(rd_line1), .rd_col(rd_col1), .rd_char(rd_char1),
    .busy(busy1), .disp_on(disp1), .cursor_on(cursor1), .blink_on(blink1),
    .inc_mode(inc1), .shift_mode(shift1), .func_dl(dl1), .func_n(n1),
    .func_f(f1), .cur_addr(cur1), .err_pulse(errp1), .err_flag(errf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_enb = 1'b1;
    tick();
    lcd_enb = 1'b0;
  endtask

  // Falling-edge strobe: high one cycle, accepted on the cycle it is seen low.
  task automatic wr1(input logic rs, input logic [7:0] d);
    rs1 = rs; rw1 = 1'b0; data1 = d; enb1 = 1'b1;
    tick();
    enb1 = 1'b0;
    tick();
  endtask

  task automatic rd_req(input bit sel, input logic ln, input logic [3:0] col, input logic [7:0] e);
    exp_q.push_back(e);
    if (sel) begin rd_line1 = ln; rd_col1 = col; end
    else     begin rd_line  = ln; rd_col  = col; end
    tick();
    got_q.push_back(sel ? rd_char1 : rd_char);
  endtask

  task automatic test_reset();
    logic [10:0] v;
    int n;
    rst = 1'b1; rst1 = 1'b1;
    tick(); tick();
    v = {busy, disp_on, cursor_on, blink_on, inc_mode, shift_mode, func_dl, func_n, func_f, err_pulse, err_flag};
    checks++;
    if (v !== 11'b1_000_10_100_00) begin failures++; $display("FAIL reset_flags got=%b exp=%b", v, 11'b1_000_10_100_00); end
    checks++;
    if (rd_char !== 8'h00 || cur_addr !== 7'h00) begin failures++; $display("FAIL reset_regs rd_char=%h cur_addr=%h exp 00/00", rd_char, cur_addr); end
    v = {busy1, disp1, cursor1, blink1, inc1, shift1, dl1, n1, f1, errp1, errf1};
    checks++;
    if (v !== 11'b1_000_10_100_00) begin failures++; $display("FAIL reset_flags1 got=%b exp=%b", v, 11'b1_000_10_100_00); end
    rst = 1'b0; rst1 = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!busy) begin n = i; break; end
    end
    checks++;
    if (n != 80) begin failures++; $display("FAIL reset_busy_len got=%0d exp=80", n); end
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
  endtask

  task automatic test_init();
    logic [7:0] v;
    logic [7:0] e, g;
    wr(0, 8'h3C); wr(0, 8'h0C); wr(0, 8'h06);
    v = {func_dl, func_n, func_f, disp_on, cursor_on, blink_on, inc_mode, shift_mode};
    checks++;
    if (v !== 8'b111_100_10) begin failures++; $display("FAIL init_flags got=%b exp=%b", v, 8'b111_100_10); end
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 16; c++) rd_req(0, l[0], c[3:0], 8'h20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL init_blank got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_text();
    logic [7:0] s [5] = '{8'h73, 8'h72, 8'h63, 8'h3A, 8'h41};
    logic [7:0] e, g;
    wr(0, 8'h80);
    for (int i = 0; i < 5; i++) wr(1, s[i]);
    wr(0, 8'hC0);
    wr(1, 8'h50);
    checks++;
    if (cur_addr !== 7'h41) begin failures++; $display("FAIL text_addr got=%h exp=41", cur_addr); end
    for (int i = 0; i < 5; i++) rd_req(0, 1'b0, i[3:0], s[i]);
    rd_req(0, 1'b1, 4'd0, 8'h50);
    rd_req(0, 1'b1, 4'd1, 8'h20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL text_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] cmd [6] = '{8'h14, 8'h10, 8'hC0, 8'h10, 8'h14, 8'h02};
    logic [6:0] ea  [6] = '{7'h00, 7'h67, 7'h40, 7'h27, 7'h40, 7'h00};
    logic [7:0] e, g;
    wr(0, 8'hA7);
    wr(1, 8'h58);
    checks++;
    if (cur_addr !== 7'h40) begin failures++; $display("FAIL wrap_27 got=%h exp=40", cur_addr); end
    wr(1, 8'h59);
    wr(0, 8'h04);
    checks++;
    if (inc_mode !== 1'b0) begin failures++; $display("FAIL wrap_inc got=%b exp=0", inc_mode); end
    wr(0, 8'h80);
    wr(1, 8'h5A);
    checks++;
    if (cur_addr !== 7'h67) begin failures++; $display("FAIL wrap_00 got=%h exp=67", cur_addr); end
    for (int i = 0; i < 6; i++) begin
      wr(0, cmd[i]);
      checks++;
      if (cur_addr !== ea[i]) begin failures++; $display("FAIL wrap_shift%0d got=%h exp=%h", i, cur_addr, ea[i]); end
    end
    rd_req(0, 1'b1, 4'd0, 8'h59);
    rd_req(0, 1'b0, 4'd0, 8'h5A);
    rd_req(0, 1'b0, 4'd1, 8'h72);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL wrap_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_clear();
    int n, pulses;
    logic [7:0] e, g;
    checks++;
    if (err_flag !== 1'b0) begin failures++; $display("FAIL clear_preflag got=%b exp=0", err_flag); end
    wr(0, 8'h01);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy got=%b exp=1", busy); end
    tick();
    wr(1, 8'h41);
    checks++;
    if ({err_pulse, err_flag} !== 2'b11) begin failures++; $display("FAIL clear_err got=%b exp=11", {err_pulse, err_flag}); end
    n = -1; pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (err_pulse) pulses++;
      if (!busy) begin n = i; break; end
    end
    checks++;
    if (n != 78) begin failures++; $display("FAIL clear_len got=%0d exp=78", n); end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL clear_extra_pulse got=%0d exp=0", pulses); end
    checks++;
    if ({cur_addr, inc_mode, err_flag} !== {7'h00, 1'b1, 1'b1}) begin
      failures++; $display("FAIL clear_state addr=%h inc=%b flag=%b exp 00/1/1", cur_addr, inc_mode, err_flag);
    end
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 16; c++) rd_req(0, l[0], c[3:0], 8'h20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL clear_blank got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] e, g;
    wr(0, 8'h83);
    wr(0, 8'hB0);
    checks++;
    if ({err_pulse, cur_addr} !== {1'b1, 7'h03}) begin failures++; $display("FAIL inv_b0 pulse=%b addr=%h exp 1/03", err_pulse, cur_addr); end
    tick();
    checks++;
    if (err_pulse !== 1'b0) begin failures++; $display("FAIL inv_pulse_len got=%b exp=0", err_pulse); end
    wr(0, 8'hE8);
    checks++;
    if ({err_pulse, cur_addr} !== {1'b1, 7'h03}) begin failures++; $display("FAIL inv_e8 pulse=%b addr=%h exp 1/03", err_pulse, cur_addr); end
    wr(0, 8'h40);
    wr(1, 8'h55);
    checks++;
    if (cur_addr !== 7'h03) begin failures++; $display("FAIL inv_cg_addr got=%h exp=03", cur_addr); end
    wr(0, 8'h85);
    wr(1, 8'h55);
    checks++;
    if (cur_addr !== 7'h06) begin failures++; $display("FAIL inv_cg_exit got=%h exp=06", cur_addr); end
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_data = 8'h77; lcd_enb = 1'b1;
    tick();
    lcd_enb = 1'b0; lcd_rw = 1'b0;
    checks++;
    if (cur_addr !== 7'h06) begin failures++; $display("FAIL inv_read_ignored got=%h exp=06", cur_addr); end
    rd_req(0, 1'b0, 4'd3, 8'h20);
    rd_req(0, 1'b0, 4'd5, 8'h55);
    rd_req(0, 1'b0, 4'd6, 8'h20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL inv_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_edge();
    logic [7:0] e, g;
    rs1 = 1'b1; rw1 = 1'b0; data1 = 8'h31; enb1 = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (cur1 !== 7'h00) begin failures++; $display("FAIL edge_high got=%h exp=00", cur1); end
    enb1 = 1'b0;
    tick();
    checks++;
    if (cur1 !== 7'h01) begin failures++; $display("FAIL edge_fall got=%h exp=01", cur1); end
    tick(); tick();
    checks++;
    if (cur1 !== 7'h01) begin failures++; $display("FAIL edge_once got=%h exp=01", cur1); end
    rd_req(1, 1'b0, 4'd0, 8'h31);
    rd_req(1, 1'b0, 4'd1, 8'h20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL edge_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_rst_mid_clear();
    int n;
    wr1(0, 8'h0F);
    checks++;
    if ({disp1, cursor1, blink1} !== 3'b111) begin failures++; $display("FAIL mid_disp got=%b exp=111", {disp1, cursor1, blink1}); end
    wr1(0, 8'h01);
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy1); end
    repeat (30) tick();
    rst1 = 1'b1;
    tick();
    checks++;
    if ({busy1, disp1, cursor1, blink1, cur1} !== {4'b1000, 7'h00}) begin
      failures++; $display("FAIL mid_rst got=%b exp=%b", {busy1, disp1, cursor1, blink1, cur1}, {4'b1000, 7'h00});
    end
    rst1 = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!busy1) begin n = i; break; end
    end
    checks++;
    if (n != 80) begin failures++; $display("FAIL mid_len got=%0d exp=80", n); end
  endtask

  initial begin
    rst = 1'b1; lcd_enb = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    rd_line = 1'b0; rd_col = 4'd0;
    rst1 = 1'b1; enb1 = 1'b0; rs1 = 1'b0; rw1 = 1'b0; data1 = 8'h00;
    rd_line1 = 1'b0; rd_col1 = 4'd0;
    test_reset();
    test_init();
    test_text();
    test_wrap();
    test_clear();
    test_invalid();
    test_edge();
    test_rst_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
